seq_digit_adder: RTL and testbench

- Parametrised multi-cycle adder that adds two WIDTH-bit operands DIGIT bits per clock.
- Each digit is summed through a DIGIT-bit ripple-carry slice; the carry is registered between digits.
- Successor to the fixed 4-bit combinational full adder: width and slice size are generic, with valid/ready handshakes on input and output.
- Sits between operand sources and result consumers in the arithmetic datapath, where a single-cycle wide ripple adder would miss timing.

---
 rtl/seq_digit_adder.sv | 122 ++++++++++++
 tb/tb_seq_digit_adder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_digit_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands DIGIT bits per clock, carry registered between digits.
// Optional subtract mode is enabled by defining SEQ_DIGIT_ADDER_SUB_EN (adds the Sub port).
module seq_digit_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef SEQ_DIGIT_ADDER_SUB_EN
   input  logic             Sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_s;
   logic [KW-1:0]    r_k;
   logic             r_carry, r_cout;
   logic [WIDTH-1:0] w_b_in;
   logic             w_c_in;
   logic [DIGIT-1:0] w_a_dig, w_b_dig;
   logic [DIGIT:0]   w_sum;

`ifdef SEQ_DIGIT_ADDER_SUB_EN
   // Subtraction as A + ~B + 1; Cin plays no part then.
   assign w_b_in = Sub ? ~B : B;
   assign w_c_in = Sub ? 1'b1 : Cin;
`else
   assign w_b_in = B;
   assign w_c_in = Cin;
`endif

   // Digit select by constant-index mux keeps every part-select static.
   always_comb begin
      w_a_dig = '0;
      w_b_dig = '0;
      for (int d = 0; d < NDIG; d++) begin
         if (r_k == KW'(d)) begin
            w_a_dig = r_a[d*DIGIT +: DIGIT];
            w_b_dig = r_b[d*DIGIT +: DIGIT];
         end
      end
   end

   assign w_sum = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = RUN;
         end
         RUN: begin
            if (r_k == K_LAST) w_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_k     <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= A;
                  r_b     <= w_b_in;
                  r_carry <= w_c_in;
                  r_k     <= '0;
                  r_s     <= '0;
                  r_cout  <= 1'b0;
               end
            end
            RUN: begin
               for (int d = 0; d < NDIG; d++) begin
                  if (r_k == KW'(d)) r_s[d*DIGIT +: DIGIT] <= w_sum[DIGIT-1:0];
               end
               r_carry <= w_sum[DIGIT];
               r_k     <= r_k + 1'b1;
               if (r_k == K_LAST) r_cout <= w_sum[DIGIT];
            end
            default: ;
         endcase
      end
   end

   assign S    = r_s;
   assign Cout = r_cout;

endmodule

// File: tb/tb_seq_digit_adder.sv
// Bench for seq_digit_adder: three instances (16/4, 8/8, 4/1), directed steps with a result scoreboard.
module tb_seq_digit_adder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [2:0]  iv, ordy;
   logic [15:0] A, B;
   logic        Cin;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
   logic        Sub;
`endif
   logic        ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2;
   logic [15:0] s0;
   logic [7:0]  s1;
   logic [3:0]  s2;

   int          checks = 0;
   int          errors = 0;
   logic [16:0] sb[$];

   seq_digit_adder #(.WIDTH(16), .DIGIT(4)) u0 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir0),
      .A(A), .B(B), .Cin(Cin),
`ifdef SEQ_DIGIT_ADDER_SUB_EN
      .Sub(Sub),
`endif
      .out_valid(ov0), .out_ready(ordy[0]), .S(s0), .Cout(co0));

   seq_digit_adder #(.WIDTH(8), .DIGIT(8)) u1 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir1),
      .A(A[7:0]), .B(B[7:0]), .Cin(Cin),
`ifdef SEQ_DIGIT_ADDER_SUB_EN
      .Sub(Sub),
`endif
      .out_valid(ov1), .out_ready(ordy[1]), .S(s1), .Cout(co1));

   seq_digit_adder #(.WIDTH(4), .DIGIT(1)) u2 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir2),
      .A(A[3:0]), .B(B[3:0]), .Cin(Cin),
`ifdef SEQ_DIGIT_ADDER_SUB_EN
      .Sub(Sub),
`endif
      .out_valid(ov2), .out_ready(ordy[2]), .S(s2), .Cout(co2));

   task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   function automatic logic [16:0] obs(input int u);
      case (u)
         0:       return {co0, s0};
         1:       return {co1, 8'h00, s1};
         default: return {co2, 12'h000, s2};
      endcase
   endfunction

   function automatic logic rdy(input int u);
      return (u == 0) ? ir0 : (u == 1) ? ir1 : ir2;
   endfunction

   function automatic logic vld(input int u);
      return (u == 0) ? ov0 : (u == 1) ? ov1 : ov2;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction: drive, push the behavioural result, wait for out_valid, compare, optional backpressure.
   task automatic op(input int u, input logic [15:0] a, input logic [15:0] b, input logic c,
                     input logic sub, input int hold, input bit arm);
      int          nd, w, lat;
      logic [15:0] m, bb;
      logic [16:0] full, exp_v, got;
      nd = (u == 0) ? 4 : (u == 1) ? 1 : 4;
      w  = (u == 0) ? 16 : (u == 1) ? 8 : 4;
      m  = 16'((17'd1 << w) - 17'd1);
      bb = sub ? ~b : b;
      full  = {1'b0, a & m} + {1'b0, bb & m} + {16'd0, (sub ? 1'b1 : c)};
      exp_v = {full[w], full[15:0] & m};
      chk("in_ready_idle", {16'd0, rdy(u)}, 17'd1);
      A = a; B = b; Cin = c;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
      Sub = sub;
`endif
      iv[u] = 1'b1;
      sb.push_back(exp_v);
      step();
      iv[u] = 1'b0;
      A = ~a; B = ~b; Cin = ~c;
      lat = 0;
      while (!vld(u) && lat < 50) begin
         step();
         lat++;
      end
      chk("latency", 17'(lat), 17'(nd));
      got = obs(u);
      chk("result", got, (sb.size() > 0) ? sb.pop_front() : 17'hx);
      for (int h = 0; h < hold; h++) begin
         if (arm && h == 0) begin
            A = 16'hAAAA; B = 16'h5555; iv[u] = 1'b1;
         end
         step();
         chk("hold_result", obs(u), exp_v);
         chk("hold_valid", {16'd0, vld(u)}, 17'd1);
         chk("hold_in_ready", {16'd0, rdy(u)}, 17'd0);
      end
      ordy[u] = 1'b1;
      step();
      ordy[u] = 1'b0;
      chk("back_idle_valid", {16'd0, vld(u)}, 17'd0);
   endtask

   initial begin
      reset_n = 1'b0; iv = '0; ordy = '0; A = '0; B = '0; Cin = 1'b0;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
      Sub = 1'b0;
`endif
      step(); step();
      reset_n = 1'b1;
      chk("rst_in_ready", {16'd0, ir0}, 17'd1);
      chk("rst_out_valid", {16'd0, ov0}, 17'd0);
      chk("rst_sum", obs(0), 17'd0);
      chk("rst_u1", {15'd0, ir1, ov1}, 17'd2);
      chk("rst_u2", {15'd0, ir2, ov2}, 17'd2);

      op(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1'b0);
      op(0, 16'h0005, 16'h0003, 1'b0, 1'b0, 0, 1'b0);
      op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
      op(0, 16'h1234, 16'h4321, 1'b1, 1'b0, 3, 1'b1);
      // in_valid has stayed high since the DONE window; this op is the one accepted back in IDLE.
      op(0, 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 0, 1'b0);

      // Reset on the second RUN cycle discards the operation.
      A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b0; iv[0] = 1'b1;
      step();
      iv[0] = 1'b0;
      step();
      reset_n = 1'b0;
      step();
      chk("midrun_rst_in_ready", {16'd0, ir0}, 17'd1);
      chk("midrun_rst_valid", {16'd0, ov0}, 17'd0);
      chk("midrun_rst_sum", obs(0), 17'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("no_stale_valid", {16'd0, ov0}, 17'd0);
      end
      op(0, 16'h0010, 16'h0020, 1'b0, 1'b0, 0, 1'b0);

      op(1, 16'h0080, 16'h0080, 1'b1, 1'b0, 1, 1'b0);
      op(1, 16'h00FF, 16'h0000, 1'b0, 1'b0, 0, 1'b0);

      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               op(2, 16'(a), 16'(b), c[0], 1'b0, 0, 1'b0);

`ifdef SEQ_DIGIT_ADDER_SUB_EN
      op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
      op(0, 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
      op(2, 16'h0003, 16'h0009, 1'b0, 1'b1, 0, 1'b0);
`endif

      chk("scoreboard_empty", 17'(sb.size()), 17'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
